orbit_sequencer: RTL and testbench
==================================

ORBIT_SEQUENCER -- requirements
Module: orbit_sequencer

Interface
REQ-001 frame_clk  in  1  clock; all state changes on rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 keycode  in  8  keyboard code: 7 = right (clockwise), 4 = left (counter-clockwise), others = no step.
REQ-004 red_dead  in  1  red ball dead; its position is frozen.
REQ-005 blue_dead  in  1  blue ball dead; its position is frozen.
REQ-006 RedX, RedY  out  10  red ball centre, pixels, unsigned.
REQ-007 BlueX, BlueY  out  10  blue ball centre, pixels, unsigned.
REQ-008 BallS  out  10  ball size, constant 4.
REQ-009 angle_idx  out  6  current red angle index, 0..59; each step is 6 degrees.
REQ-010 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Circle parameters SHALL be fixed: centre (320,240), radius 80, 60 angle positions.
REQ-012 The blue index SHALL always be (angle_idx+30) mod 60, i.e. 180 degrees opposite red.
REQ-013 A single synchronous trig ROM SHALL be shared by both balls, one read per cycle, 1-cycle read latency.
REQ-014 ROM entry k SHALL hold cos = round(256*cos(6k deg)) and sin = round(256*sin(6k deg)), both 10-bit signed.
REQ-015 Position arithmetic SHALL be X = 320 + ((80*cos) >>> 8) and Y = 240 + ((80*sin) >>> 8).
REQ-016 Those products SHALL be 18-bit signed, with an arithmetic shift (floor), and the result truncated to 10 bits.
REQ-017 FSM states SHALL be IDLE, ADDR_R, ADDR_B, LAST, COMMIT.
REQ-018 IDLE, keycode 7: angle_idx <= (angle_idx+1) mod 60 (59->0); go to ADDR_R.
REQ-019 IDLE, keycode 4: angle_idx <= (angle_idx-1) mod 60 (0->59); go to ADDR_R.
REQ-020 IDLE, any other keycode: stay in IDLE with no change.
REQ-021 ADDR_R SHALL issue the ROM read at the red index, then go to ADDR_B.
REQ-022 ADDR_B SHALL compute the pending red position from the ROM data and issue the ROM read at the blue index, then go to LAST.
REQ-023 LAST SHALL compute the pending blue position, then go to COMMIT.
REQ-024 COMMIT SHALL update the position outputs of both live balls on the same edge, then go to IDLE.
REQ-025 Latency: a key sampled at edge N SHALL update angle_idx at N and the position outputs at N+4.
REQ-026 busy SHALL be high for cycles N..N+4.
REQ-027 keycode SHALL be ignored outside IDLE.
REQ-028 A held key SHALL produce one step every 5 cycles.
REQ-029 A dead ball SHALL keep its outputs unchanged at COMMIT; the ROM schedule is unchanged.
REQ-030 With both dead flags set, keys SHALL be ignored in IDLE and angle_idx SHALL be frozen.
REQ-031 Dead flags SHALL be sampled at COMMIT only.

Reset
REQ-032 Reset SHALL drive: angle_idx 0, RedX 400, RedY 240, BlueX 240, BlueY 240, BallS 4, busy 0, state IDLE.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no partial commit.
REQ-034 The first key after reset release SHALL be accepted in IDLE.

Structure
REQ-035 Package orbit_pkg SHALL hold the centre, radius, step count (60), half-turn offset (30), keycodes 7/4, ball size, and the FSM state enum.
REQ-036 Sub-module trig_rom SHALL hold the 60x(10+10) table with a 6-bit address and a registered output; no other sub-modules.

Verification
REQ-037 Reset -> Red (400,240), Blue (240,240), angle_idx 0, busy 0.
REQ-038 One-cycle keycode 7 -> busy high 5 cycles; angle_idx 1; Red (399,248); Blue (240,231) at N+4.
REQ-039 One-cycle keycode 4 from reset -> angle_idx 59; Red (399,231); Blue (240,248).
REQ-040 keycode 7 held 300 cycles -> 60 commits; angle_idx back to 0; Red (400,240).
REQ-041 red_dead=1 with keycode 7 pulse -> Red stays (400,240); Blue becomes (240,231).
REQ-042 Reset pulse during ADDR_B -> reset values on the next edge; no commit follows.

Source files
------------

// File: rtl/orbit_pkg.sv
// Shared constants, FSM state type and position helpers for the orbit sequencer.
// Both balls ride one circle of 60 positions; blue sits half a turn ahead of red.
package orbit_pkg;

   localparam int CENTRE_X  = 320;
   localparam int CENTRE_Y  = 240;
   localparam int RADIUS    = 80;
   localparam int STEPS     = 60;
   localparam int HALF_TURN = 30;
   localparam int BALL_SIZE = 4;

   localparam logic [7:0] KEY_CW  = 8'd7;
   localparam logic [7:0] KEY_CCW = 8'd4;

   typedef enum logic [2:0] {IDLE, ADDR_R, ADDR_B, LAST, COMMIT} state_t;

   // Q8 fixed-point cosine/sine pair.
   typedef struct packed {
      logic signed [9:0] cos_v;
      logic signed [9:0] sin_v;
   } trig_t;

   function automatic logic [5:0] opposite(logic [5:0] idx);
      return (idx >= 6'(HALF_TURN)) ? idx - 6'(HALF_TURN) : idx + 6'(HALF_TURN);
   endfunction

   // centre + floor(radius*t / 256), wrapped to the 10-bit pixel range.
   function automatic logic [9:0] place(int centre, logic signed [9:0] t);
      logic signed [17:0] prod;
      prod = 18'(RADIUS) * 18'(t);
      return 10'(centre) + 10'(prod >>> 8);
   endfunction

endpackage

// File: rtl/orbit_sequencer_if.sv
// Key/dead-flag inputs and ball-position outputs of the orbit sequencer.
// master is the game side driving keys; slave is the sequencer itself.
interface orbit_sequencer_if;
   logic [7:0] keycode;
   logic       red_dead;
   logic       blue_dead;
   logic [9:0] RedX;
   logic [9:0] RedY;
   logic [9:0] BlueX;
   logic [9:0] BlueY;
   logic [9:0] BallS;
   logic [5:0] angle_idx;
   logic       busy;

   modport master (
      output keycode, red_dead, blue_dead,
      input  RedX, RedY, BlueX, BlueY, BallS, angle_idx, busy
   );

   modport slave (
      input  keycode, red_dead, blue_dead,
      output RedX, RedY, BlueX, BlueY, BallS, angle_idx, busy
   );
endinterface

// File: rtl/orbit_sequencer_trig_rom.sv
// 60-entry synchronous cos/sin table, entry k = round(256*cos/sin(6k deg)).
// One read per cycle, data valid the cycle after the address is presented.
module trig_rom
   import orbit_pkg::*;
(
   input  logic       frame_clk,
   input  logic [5:0] addr,
   output trig_t      data
);

   // NOTE: a ROM output register needs no reset; every read overwrites it before use.
   always_ff @(posedge frame_clk) begin
      case (addr)
         6'd0:  data <= '{ 10'sd256,   10'sd0   };
         6'd1:  data <= '{ 10'sd255,   10'sd27  };
         6'd2:  data <= '{ 10'sd250,   10'sd53  };
         6'd3:  data <= '{ 10'sd243,   10'sd79  };
         6'd4:  data <= '{ 10'sd234,   10'sd104 };
         6'd5:  data <= '{ 10'sd222,   10'sd128 };
         6'd6:  data <= '{ 10'sd207,   10'sd150 };
         6'd7:  data <= '{ 10'sd190,   10'sd171 };
         6'd8:  data <= '{ 10'sd171,   10'sd190 };
         6'd9:  data <= '{ 10'sd150,   10'sd207 };
         6'd10: data <= '{ 10'sd128,   10'sd222 };
         6'd11: data <= '{ 10'sd104,   10'sd234 };
         6'd12: data <= '{ 10'sd79,    10'sd243 };
         6'd13: data <= '{ 10'sd53,    10'sd250 };
         6'd14: data <= '{ 10'sd27,    10'sd255 };
         6'd15: data <= '{ 10'sd0,     10'sd256 };
         6'd16: data <= '{ -10'sd27,   10'sd255 };
         6'd17: data <= '{ -10'sd53,   10'sd250 };
         6'd18: data <= '{ -10'sd79,   10'sd243 };
         6'd19: data <= '{ -10'sd104,  10'sd234 };
         6'd20: data <= '{ -10'sd128,  10'sd222 };
         6'd21: data <= '{ -10'sd150,  10'sd207 };
         6'd22: data <= '{ -10'sd171,  10'sd190 };
         6'd23: data <= '{ -10'sd190,  10'sd171 };
         6'd24: data <= '{ -10'sd207,  10'sd150 };
         6'd25: data <= '{ -10'sd222,  10'sd128 };
         6'd26: data <= '{ -10'sd234,  10'sd104 };
         6'd27: data <= '{ -10'sd243,  10'sd79  };
         6'd28: data <= '{ -10'sd250,  10'sd53  };
         6'd29: data <= '{ -10'sd255,  10'sd27  };
         6'd30: data <= '{ -10'sd256,  10'sd0   };
         6'd31: data <= '{ -10'sd255, -10'sd27  };
         6'd32: data <= '{ -10'sd250, -10'sd53  };
         6'd33: data <= '{ -10'sd243, -10'sd79  };
         6'd34: data <= '{ -10'sd234, -10'sd104 };
         6'd35: data <= '{ -10'sd222, -10'sd128 };
         6'd36: data <= '{ -10'sd207, -10'sd150 };
         6'd37: data <= '{ -10'sd190, -10'sd171 };
         6'd38: data <= '{ -10'sd171, -10'sd190 };
         6'd39: data <= '{ -10'sd150, -10'sd207 };
         6'd40: data <= '{ -10'sd128, -10'sd222 };
         6'd41: data <= '{ -10'sd104, -10'sd234 };
         6'd42: data <= '{ -10'sd79,  -10'sd243 };
         6'd43: data <= '{ -10'sd53,  -10'sd250 };
         6'd44: data <= '{ -10'sd27,  -10'sd255 };
         6'd45: data <= '{ 10'sd0,    -10'sd256 };
         6'd46: data <= '{ 10'sd27,   -10'sd255 };
         6'd47: data <= '{ 10'sd53,   -10'sd250 };
         6'd48: data <= '{ 10'sd79,   -10'sd243 };
         6'd49: data <= '{ 10'sd104,  -10'sd234 };
         6'd50: data <= '{ 10'sd128,  -10'sd222 };
         6'd51: data <= '{ 10'sd150,  -10'sd207 };
         6'd52: data <= '{ 10'sd171,  -10'sd190 };
         6'd53: data <= '{ 10'sd190,  -10'sd171 };
         6'd54: data <= '{ 10'sd207,  -10'sd150 };
         6'd55: data <= '{ 10'sd222,  -10'sd128 };
         6'd56: data <= '{ 10'sd234,  -10'sd104 };
         6'd57: data <= '{ 10'sd243,  -10'sd79  };
         6'd58: data <= '{ 10'sd250,  -10'sd53  };
         6'd59: data <= '{ 10'sd255,  -10'sd27  };
         default: data <= '{ 10'sd0,  10'sd0   };
      endcase
   end

endmodule

// File: rtl/orbit_sequencer.sv
// Steps the red ball around the circle on left/right keys and places blue opposite it,
// sharing one trig ROM between the two balls over a five-cycle sequence.
module orbit_sequencer
   import orbit_pkg::*;
(
   input  logic           frame_clk,
   input  logic           Reset,
   orbit_sequencer_if.slave bus
);

   state_t     state;
   logic [5:0] angle;
   logic [5:0] rom_addr;
   trig_t      rom_data;
   logic [9:0] red_x, red_y, blue_x, blue_y;
   logic [9:0] pend_rx, pend_ry, pend_bx, pend_by;
   logic       busy_q;
   logic       step_cw, step_ccw, frozen;

   assign step_cw  = (bus.keycode == KEY_CW);
   assign step_ccw = (bus.keycode == KEY_CCW);
   assign frozen   = bus.red_dead && bus.blue_dead;

   // Red is read in every cycle except ADDR_B, so ADDR_R's read lands in ADDR_B.
   assign rom_addr = (state == ADDR_B) ? opposite(angle) : angle;

   trig_rom u_trig_rom (
      .frame_clk (frame_clk),
      .addr      (rom_addr),
      .data      (rom_data)
   );

   // NOTE: every register here is sequential state, so all updates use non-blocking <=.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         angle   <= '0;
         red_x   <= 10'(CENTRE_X + RADIUS);
         red_y   <= 10'(CENTRE_Y);
         blue_x  <= 10'(CENTRE_X - RADIUS);
         blue_y  <= 10'(CENTRE_Y);
         pend_rx <= '0;
         pend_ry <= '0;
         pend_bx <= '0;
         pend_by <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((step_cw || step_ccw) && !frozen) begin
                  if (step_cw)
                     angle <= (angle == 6'(STEPS - 1)) ? 6'd0 : angle + 6'd1;
                  else
                     angle <= (angle == 6'd0) ? 6'(STEPS - 1) : angle - 6'd1;
                  busy_q <= 1'b1;
                  state  <= ADDR_R;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            ADDR_R: state <= ADDR_B;
            ADDR_B: begin
               pend_rx <= place(CENTRE_X, rom_data.cos_v);
               pend_ry <= place(CENTRE_Y, rom_data.sin_v);
               state   <= LAST;
            end
            LAST: begin
               pend_bx <= place(CENTRE_X, rom_data.cos_v);
               pend_by <= place(CENTRE_Y, rom_data.sin_v);
               state   <= COMMIT;
            end
            COMMIT: begin
               // busy stays high into the following IDLE cycle so it spans the commit.
               if (!bus.red_dead) begin
                  red_x <= pend_rx;
                  red_y <= pend_ry;
               end
               if (!bus.blue_dead) begin
                  blue_x <= pend_bx;
                  blue_y <= pend_by;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.RedX      = red_x;
   assign bus.RedY      = red_y;
   assign bus.BlueX     = blue_x;
   assign bus.BlueY     = blue_y;
   assign bus.BallS     = 10'(BALL_SIZE);
   assign bus.angle_idx = angle;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_orbit_sequencer.sv
// Bench for orbit_sequencer: a trigonometric reference model checked every cycle,
// plus directed scenarios with hand-computed positions.
module tb_orbit_sequencer;

   logic frame_clk = 1'b0;
   logic Reset;
   bit   cmp_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   orbit_sequencer_if bus ();

   orbit_sequencer dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference positions from real trigonometry, rounded to Q8 then scaled by the radius.
   function automatic int q8(int k, bit use_sin);
      real a, v;
      a = 6.0 * k * 3.14159265358979 / 180.0;
      v = 256.0 * (use_sin ? $sin(a) : $cos(a));
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   function automatic int pos_x(int k);
      int p;
      p = 80 * q8(k, 1'b0);
      return 320 + (p >>> 8);
   endfunction

   function automatic int pos_y(int k);
      int p;
      p = 80 * q8(k, 1'b1);
      return 240 + (p >>> 8);
   endfunction

   int m_angle, m_rx, m_ry, m_bx, m_by, m_cnt;
   bit m_busy;

   // Model: an accepted key steps the angle at once; positions appear four edges later.
   always @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         m_angle = 0; m_cnt = 0; m_busy = 1'b0;
         m_rx = 400; m_ry = 240; m_bx = 240; m_by = 240;
      end else if (m_cnt == 0) begin
         if ((bus.keycode == 8'd7 || bus.keycode == 8'd4) && !(bus.red_dead && bus.blue_dead)) begin
            m_angle = (bus.keycode == 8'd7) ? (m_angle + 1) % 60 : (m_angle + 59) % 60;
            m_cnt   = 1;
            m_busy  = 1'b1;
         end else begin
            m_busy = 1'b0;
         end
      end else if (m_cnt == 4) begin
         if (!bus.red_dead) begin
            m_rx = pos_x(m_angle);
            m_ry = pos_y(m_angle);
         end
         if (!bus.blue_dead) begin
            m_bx = pos_x((m_angle + 30) % 60);
            m_by = pos_y((m_angle + 30) % 60);
         end
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   end

   always @(negedge frame_clk) begin
      if (cmp_en) begin
         check("cmp_RedX",      int'(bus.RedX),      m_rx);
         check("cmp_RedY",      int'(bus.RedY),      m_ry);
         check("cmp_BlueX",     int'(bus.BlueX),     m_bx);
         check("cmp_BlueY",     int'(bus.BlueY),     m_by);
         check("cmp_BallS",     int'(bus.BallS),     4);
         check("cmp_angle_idx", int'(bus.angle_idx), m_angle);
         check("cmp_busy",      int'(bus.busy),      int'(m_busy));
      end
   end

   task automatic hold_key(input logic [7:0] k, input int n);
      @(posedge frame_clk); #2;
      bus.keycode = k;
      repeat (n) @(posedge frame_clk);
      #2 bus.keycode = 8'd0;
   endtask

   task automatic apply_reset();
      @(posedge frame_clk); #2 Reset = 1'b1;
      @(posedge frame_clk); #2 Reset = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge frame_clk);
   endtask

   task automatic check_pos(input string tag, input int rx, input int ry, input int bx, input int by);
      check({tag, "_RedX"},  int'(bus.RedX),  rx);
      check({tag, "_RedY"},  int'(bus.RedY),  ry);
      check({tag, "_BlueX"}, int'(bus.BlueX), bx);
      check({tag, "_BlueY"}, int'(bus.BlueY), by);
   endtask

   initial begin
      int busy_cnt, steps, prev;
      Reset = 1'b1;
      bus.keycode = 8'd0;
      bus.red_dead = 1'b0;
      bus.blue_dead = 1'b0;
      repeat (3) @(posedge frame_clk);
      #2 Reset = 1'b0;
      cmp_en = 1'b1;

      @(negedge frame_clk);
      check_pos("reset", 400, 240, 240, 240);
      check("reset_angle", int'(bus.angle_idx), 0);
      check("reset_busy",  int'(bus.busy), 0);

      // Single right step: busy for five cycles, positions at angle 1.
      hold_key(8'd7, 1);
      busy_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge frame_clk);
         if (bus.busy) busy_cnt++;
      end
      check("cw_busy_cycles", busy_cnt, 5);
      check("cw_angle", int'(bus.angle_idx), 1);
      check_pos("cw", 399, 248, 240, 231);
      check("model_pin_rx", m_rx, 399);
      check("model_pin_by", m_by, 231);

      // Left step from reset wraps to 59; extra key cycles while busy are ignored.
      apply_reset();
      hold_key(8'd4, 3);
      wait_cycles(8);
      check("ccw_angle", int'(bus.angle_idx), 59);
      check_pos("ccw", 399, 231, 240, 248);

      // Held right key: one step every five cycles, full turn in 300 cycles.
      apply_reset();
      @(posedge frame_clk); #2;
      bus.keycode = 8'd7;
      prev = int'(bus.angle_idx);
      steps = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge frame_clk);
         if (int'(bus.angle_idx) != prev) steps++;
         prev = int'(bus.angle_idx);
      end
      bus.keycode = 8'd0;
      wait_cycles(6);
      check("held_steps", steps, 60);
      check("held_angle", int'(bus.angle_idx), 0);
      check_pos("held", 400, 240, 240, 240);

      // Red dead: red frozen, blue still moves.
      apply_reset();
      bus.red_dead = 1'b1;
      hold_key(8'd7, 1);
      wait_cycles(8);
      check("rdead_angle", int'(bus.angle_idx), 1);
      check_pos("rdead", 400, 240, 240, 231);

      // Both dead: key ignored entirely.
      bus.blue_dead = 1'b1;
      hold_key(8'd7, 1);
      wait_cycles(8);
      check("bdead_angle", int'(bus.angle_idx), 1);
      check("bdead_busy",  int'(bus.busy), 0);
      check_pos("bdead", 400, 240, 240, 231);

      // Blue dead only: red moves to angle 0, blue keeps its old spot.
      bus.red_dead = 1'b0;
      hold_key(8'd4, 1);
      wait_cycles(8);
      check("blue_dead_angle", int'(bus.angle_idx), 0);
      check_pos("blue_dead", 400, 240, 240, 231);
      bus.blue_dead = 1'b0;

      // Reset while in ADDR_B aborts the sequence with no commit.
      apply_reset();
      hold_key(8'd7, 1);
      @(posedge frame_clk);
      #3 Reset = 1'b1;
      @(negedge frame_clk);
      check("abort_angle_in_reset", int'(bus.angle_idx), 0);
      check("abort_busy_in_reset",  int'(bus.busy), 0);
      @(posedge frame_clk); #2 Reset = 1'b0;
      wait_cycles(8);
      check("abort_angle", int'(bus.angle_idx), 0);
      check_pos("abort", 400, 240, 240, 240);

      // First key after release is accepted.
      hold_key(8'd7, 1);
      wait_cycles(8);
      check("post_reset_angle", int'(bus.angle_idx), 1);
      check_pos("post_reset", 399, 248, 240, 231);

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
